vram_port_arbiter: RTL
======================

// Module: vram_port_arbiter
// PURPOSE
//  Parametrised time-window arbiter for the single framebuffer RAM port.
//  Channel 0 (VGA scan-out) owns the port outside the blanking window.
//  Inside the window, channels 1..NUM_CH-1 (draw/clear/DMA masters) share the
//  port by round-robin with a bounded burst.
//  The port outputs are registered. Each channel gets a valid/ready-style grant.
// PARAMETERS
//  NUM_CH     2        number of channels, >=2; channel 0 = scan-out
//  AW         19       address width
//  DW         16       data width
//  FRAME_LEN  1048576  frame counter period in clk cycles
//  WIN_START  181440   first counter value of the shared window; < FRAME_LEN
//  BURST      64       max consecutive grants to one channel, >=1
//  CW         $clog2(FRAME_LEN)  counter width (derived localparam)
// PORTS
//  clk        in   1          system clock
//  rstn       in   1          asynchronous active-low reset
//  en         in   1          enables sharing; 0 = channel 0 always owns
//  req        in   NUM_CH     per-channel request; req[0] ignored
//  addr_in    in   NUM_CH*AW  packed addresses, channel i at [i*AW +: AW]
//  dwrite_in  in   NUM_CH*DW  packed write data, channel i at [i*DW +: DW]
//  wr_in      in   NUM_CH     per-channel write strobe
//  gnt        out  NUM_CH     one-hot grant, combinational from state and req
//  addr       out  AW         registered RAM address
//  dwrite     out  DW         registered RAM write data
//  wr         out  1          registered RAM write enable
//  sel        out  $clog2(NUM_CH)  registered index of the channel on the port
//  blank      out  1          1 while cnt >= WIN_START
// BEHAVIOUR
//  - Reset (rstn=0, async): addr=0, dwrite=0, wr=0, sel=0, cnt=0, owner=0,
//    bcnt=0, rr_ptr=1. While in reset, gnt=1 on channel 0 only.
//  - cnt counts 0..FRAME_LEN-1 every clk, then wraps to 0. blank=(cnt>=WIN_START).
//  - Combinational choice nsel, evaluated every cycle:
//    * !en or !blank: nsel=0.
//    * else if owner!=0, req[owner]=1 and bcnt<BURST: nsel=owner (burst holds).
//    * else: nsel = first i with req[i]=1, searching rr_ptr..NUM_CH-1, then
//      1..rr_ptr-1. If no channel requests, nsel=0.
//  - gnt = onehot(nsel). A transfer of channel i is accepted at the edge where
//    gnt[i]=1. The master must hold addr/dwrite/wr stable while req=1 and gnt=0.
//  - At each posedge: addr/dwrite/wr <= channel nsel inputs (1-cycle latency);
//    sel <= nsel.
//    * nsel==0: owner=0, bcnt=0.
//    * nsel==owner: bcnt<=bcnt+1.
//    * nsel!=owner and nsel!=0: owner=nsel, bcnt=1.
//    * nsel!=0: rr_ptr <= nsel+1, wrapping NUM_CH to 1.
//  - States: IDLE (owner=0) and OWN(k). IDLE->OWN(k) on window and req.
//    OWN(k)->OWN(j) on burst expiry or when req[k] drops with another request
//    pending. OWN->IDLE on window close, en=0, or no requests.
//  - Window close (cnt wraps to 0) or en falling aborts a burst at once: nsel=0
//    in that same cycle, with no extra cycle for the owner.
//  - Burst expiry with no other requester: the same channel is re-granted with
//    bcnt=1 and no channel-0 gap.
//  - req[owner] dropping mid-burst hands over in that same cycle.
//  - NUM_CH=2, BURST>=FRAME_LEN, req[1]=1: equals the legacy single-window switch,
//    plus one register stage.
// TESTING
//  T1 rstn=0 mid-burst, NUM_CH=4 -> addr=0, wr=0, sel=0 asynchronously; after
//     release cnt=1 on the first edge and gnt=4'b0001.
//  T2 en=0, req=2'b10, cnt>=WIN_START -> gnt=2'b01; addr equals addr_in[0]
//     delayed by one clk.
//  T3 NUM_CH=4, BURST=2, req=4'b1110 held in window -> sel sequence
//     1,1,2,2,3,3,1,1; no channel 0 cycles.
//  T4 FRAME_LEN=16, WIN_START=12, req[1]=1 -> gnt[1] during cnt 12..15,
//     gnt[0] at cnt=0; owner=0 and bcnt=0 after that edge.
//  T5 NUM_CH=3, ch2 owns with bcnt=3, req[2] drops, req[1]=1 -> gnt=3'b010 in
//     the same cycle; sel=1 next cycle.
//  T6 BURST=4, only req[1]=1 for 10 window cycles -> sel=1 throughout;
//     bcnt goes 1,2,3,4,1,2,...

Source files
------------

// File: rtl/vram_port_arbiter.sv
// Framebuffer RAM port arbiter: scan-out (channel 0) owns the port outside the
// blanking window; inside it, channels 1..NUM_CH-1 share it round-robin with bounded bursts.
module vram_port_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int AW        = 19,
  parameter int DW        = 16,
  parameter int FRAME_LEN = 1048576,
  parameter int WIN_START = 181440,
  parameter int BURST     = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH*AW-1:0]      addr_in,
  input  logic [NUM_CH*DW-1:0]      dwrite_in,
  input  logic [NUM_CH-1:0]         wr_in,
  output logic [NUM_CH-1:0]         gnt,
  output logic [AW-1:0]             addr,
  output logic [DW-1:0]             dwrite,
  output logic                      wr,
  output logic [$clog2(NUM_CH)-1:0] sel,
  output logic                      blank
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam int SW = $clog2(NUM_CH);
  localparam int BW = $clog2(BURST + 1);

  // Owner encoding: IDLE means scan-out holds the port; any other value is OWN(k).
  localparam logic [SW-1:0] IDLE = '0;

  logic [CW-1:0] cnt;
  logic [SW-1:0] owner;
  logic [SW-1:0] rr_ptr;
  logic [BW-1:0] bcnt;
  logic [SW-1:0] nsel;
  logic          hold;
  logic          found;
  logic [SW:0]   idx;

  assign blank = (cnt >= CW'(WIN_START));
  assign hold  = (owner != IDLE) && req[owner] && (bcnt < BW'(BURST));

  // The choice is forced to scan-out while in reset so gnt shows channel 0 only.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    nsel  = IDLE;
    found = 1'b0;
    idx   = '0;
    if (rstn && en && blank) begin
      if (hold) begin
        nsel  = owner;
        found = 1'b1;
      end else begin
        for (int k = 0; k < NUM_CH - 1; k++) begin
          idx = {1'b0, rr_ptr} + (SW+1)'(k);
          if (idx >= (SW+1)'(NUM_CH)) idx = idx - (SW+1)'(NUM_CH - 1);
          if (!found && req[idx[SW-1:0]]) begin
            nsel  = idx[SW-1:0];
            found = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    gnt       = '0;
    gnt[nsel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      cnt    <= '0;
      owner  <= IDLE;
      bcnt   <= '0;
      rr_ptr <= SW'(1);
      addr   <= '0;
      dwrite <= '0;
      wr     <= 1'b0;
      sel    <= '0;
    end else begin
      cnt    <= (cnt == CW'(FRAME_LEN - 1)) ? '0 : cnt + 1'b1;
      addr   <= addr_in[nsel*AW +: AW];
      dwrite <= dwrite_in[nsel*DW +: DW];
      wr     <= wr_in[nsel];
      sel    <= nsel;

      if (nsel == IDLE) begin
        owner <= IDLE;
        bcnt  <= '0;
      end else if (hold && nsel == owner) begin
        bcnt <= bcnt + 1'b1;
      end else begin
        // New owner, or expired burst re-granted to the same channel: restart the count.
        owner <= nsel;
        bcnt  <= BW'(1);
      end

      if (nsel != IDLE) begin
        rr_ptr <= (nsel == SW'(NUM_CH - 1)) ? SW'(1) : nsel + 1'b1;
      end
    end
  end

endmodule
